// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame/baud constants
// used by both the receive and transmit paths.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchronizer for bringing a single asynchronous bit into
// the clk domain; RESET_VAL lets idle-high lines reset to their idle level.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic stage2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= RESET_VAL;
            stage2 <= RESET_VAL;
        end else begin
            meta   <= d;
            stage2 <= meta;
        end
    end

    assign q = stage2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver running on the system clock with a bit-period counter,
// mid-bit sampling and a one-deep holding register with valid/ack handshake.
module uart_rx #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RX_Data_in,
    input  logic                 RX_Ack,
    output logic [DATA_BITS-1:0] RX_Data_out,
    output logic                 RX_Valid,
    output logic                 RX_Frame_Error,
    output logic                 RX_Overrun,
    output logic                 RX_Busy
);

    import uart_pkg::*;

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    rx_state_t              state;
    rx_state_t              state_next;
    logic                   rx_s;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   half_tick;
    logic                   full_tick;
    logic                   rx_done;

    uart_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RX_Data_in),
        .q     (rx_s)
    );

    assign half_tick = (bit_cnt == HALF_CNT);
    assign full_tick = (bit_cnt == FULL_CNT);
    assign RX_Busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START:     if (half_tick) state_next = rx_s ? IDLE : DATA;
            DATA:      if (full_tick && bit_idx == LAST_IDX) state_next = STOP;
            STOP:      if (full_tick) state_next = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // The counter restarts on every state entry and at each data-bit boundary,
    // so a non power-of-two bit period never relies on natural wrap-around.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (state_next != state || state == IDLE || state == WAIT_IDLE ||
                     (state == DATA && full_tick)) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx        <= 3'd0;
            shift_reg      <= '0;
            rx_done        <= 1'b0;
            RX_Frame_Error <= 1'b0;
        end else begin
            rx_done        <= (state == STOP) && full_tick && rx_s;
            RX_Frame_Error <= (state == STOP) && full_tick && !rx_s;
            if (state == START && half_tick) begin
                bit_idx <= 3'd0;
            end else if (state == DATA && full_tick) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    // A completion with the register full only succeeds if the consumer is
    // acknowledging in that same cycle; otherwise the new byte is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RX_Data_out <= '0;
            RX_Valid    <= 1'b0;
            RX_Overrun  <= 1'b0;
        end else if (rx_done) begin
            if (!RX_Valid || RX_Ack) begin
                RX_Data_out <= shift_reg;
                RX_Valid    <= 1'b1;
            end
            if (RX_Valid && !RX_Ack) begin
                RX_Overrun <= 1'b1;
            end else if (RX_Ack) begin
                RX_Overrun <= 1'b0;
            end
        end else if (RX_Ack) begin
            RX_Valid   <= 1'b0;
            RX_Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios followed by random
// frames, all compared against a frame-level model of the holding register.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       RX_Data_in;
    logic       RX_Ack;
    logic [7:0] RX_Data_out;
    logic       RX_Valid;
    logic       RX_Frame_Error;
    logic       RX_Overrun;
    logic       RX_Busy;

    int checks = 0;
    int errors = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    int lat;

    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .RX_Data_in     (RX_Data_in),
        .RX_Ack         (RX_Ack),
        .RX_Data_out    (RX_Data_out),
        .RX_Valid       (RX_Valid),
        .RX_Frame_Error (RX_Frame_Error),
        .RX_Overrun     (RX_Overrun),
        .RX_Busy        (RX_Busy)
    );

    always #5 clk = ~clk;

    // Each sampled-high cycle counts, so a pulse longer than one cycle is seen as extra errors.
    always @(negedge clk) begin
        if (RX_Frame_Error === 1'b1) fe_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame, LSB first, each bit held for CPB clock edges.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX_Data_in = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic modelReset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic modelComplete(input logic [7:0] b, input logic ack_now);
        logic was_valid;
        was_valid = exp_valid;
        if (!was_valid || ack_now) begin
            exp_data  = b;
            exp_valid = 1'b1;
        end
        if (was_valid && !ack_now) exp_ovr = 1'b1;
        else if (ack_now)          exp_ovr = 1'b0;
    endtask

    task automatic pulseAck();
        RX_Ack = 1'b1;
        idleCycles(1);
        RX_Ack = 1'b0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic checkHolding(input string tag);
        checkOutput({tag, "_data"},    RX_Data_out, exp_data);
        checkOutput({tag, "_valid"},   RX_Valid,    exp_valid);
        checkOutput({tag, "_overrun"}, RX_Overrun,  exp_ovr);
        checkOutput({tag, "_ferr_cnt"}, fe_seen,    fe_exp);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       bad;
        int         gap;

        reset      = 1'b1;
        RX_Data_in = 1'b1;
        RX_Ack     = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkHolding("reset");
        checkOutput("reset_busy", RX_Busy, 1'b0);
        checkOutput("reset_ferr", RX_Frame_Error, 1'b0);
        reset = 1'b0;
        idleCycles(4);

        $display("[TB] nominal 0xA5 frame");
        lat = -1;
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                for (int k = 0; k < 300; k++) begin
                    @(posedge clk);
                    lat++;
                    #1;
                    if (RX_Valid) break;
                end
            end
        join
        checkOutput("nominal_latency_in_window", (lat >= 154 && lat <= 156), 1'b1);
        modelComplete(8'hA5, 1'b0);
        idleCycles(2);
        checkHolding("nominal");
        checkOutput("nominal_byte", RX_Data_out, 8'hA5);
        checkOutput("nominal_busy", RX_Busy, 1'b0);
        pulseAck();
        checkOutput("nominal_ack_clears_valid", RX_Valid, 1'b0);

        $display("[TB] start glitch");
        RX_Data_in = 1'b0;
        idleCycles(4);
        RX_Data_in = 1'b1;
        idleCycles(30);
        checkOutput("glitch_valid", RX_Valid, 1'b0);
        checkOutput("glitch_ferr_cnt", fe_seen, fe_exp);
        checkOutput("glitch_busy", RX_Busy, 1'b0);
        applyStimulus(8'h3C, 1'b1);
        modelComplete(8'h3C, 1'b0);
        idleCycles(2);
        checkHolding("after_glitch");
        pulseAck();

        $display("[TB] framing error with held-low line");
        applyStimulus(8'h3C, 1'b0);
        RX_Data_in = 1'b0;
        idleCycles(40);
        fe_exp++;
        checkHolding("ferr");
        checkOutput("ferr_busy_line_low", RX_Busy, 1'b1);
        RX_Data_in = 1'b1;
        idleCycles(5);
        checkOutput("ferr_busy_released", RX_Busy, 1'b0);
        applyStimulus(8'h7E, 1'b1);
        modelComplete(8'h7E, 1'b0);
        idleCycles(2);
        checkHolding("after_ferr");
        pulseAck();

        $display("[TB] overrun");
        applyStimulus(8'h11, 1'b1);
        modelComplete(8'h11, 1'b0);
        idleCycles(2);
        applyStimulus(8'h22, 1'b1);
        modelComplete(8'h22, 1'b0);
        idleCycles(2);
        checkHolding("overrun");
        checkOutput("overrun_flag", RX_Overrun, 1'b1);
        pulseAck();
        checkHolding("overrun_ack");

        $display("[TB] ack coincident with completion");
        applyStimulus(8'h11, 1'b1);
        modelComplete(8'h11, 1'b0);
        idleCycles(2);
        fork
            applyStimulus(8'h22, 1'b1);
            begin
                idleCycles(155);
                RX_Ack = 1'b1;
                idleCycles(1);
                RX_Ack = 1'b0;
            end
        join
        modelComplete(8'h22, 1'b1);
        idleCycles(2);
        checkHolding("coincident");
        checkOutput("coincident_byte", RX_Data_out, 8'h22);

        $display("[TB] reset mid-frame");
        RX_Data_in = 1'b0;
        idleCycles(CPB);
        RX_Data_in = 1'b1;
        idleCycles(3 * CPB + CPB / 2);
        checkOutput("midframe_busy_before_reset", RX_Busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkHolding("midframe_reset");
        checkOutput("midframe_reset_busy", RX_Busy, 1'b0);
        idleCycles(3);
        reset = 1'b0;
        idleCycles(2 * CPB);
        applyStimulus(8'h5A, 1'b1);
        modelComplete(8'h5A, 1'b0);
        idleCycles(2);
        checkHolding("after_reset");
        pulseAck();

        $display("[TB] random frames");
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            gap = $urandom_range(4, 24);
            applyStimulus(b, !bad);
            RX_Data_in = 1'b1;
            if (bad) fe_exp++;
            else     modelComplete(b, 1'b0);
            idleCycles(gap);
            checkHolding("rand");
            checkOutput("rand_busy", RX_Busy, 1'b0);
            if ($urandom_range(0, 1) == 1) pulseAck();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Single-clock UART receiver: the receive-side counterpart to the team's UART transmitter, decoding 8N1 frames from the RS232 peripheral line.
- Runs entirely in the 100 MHz system domain using a bit-period counter, so no slow UART clock and no extra clock-domain crossing.
- Presents each received byte in a one-deep holding register with a valid/acknowledge handshake to the consuming module.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit period (115200 baud at 100 MHz); legal range >= 4.
DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
RX_Data_in  input  1  serial line from RS232 peripheral, asynchronous, idles high
RX_Ack  input  1  consumer acknowledges the held byte; sampled on the clk rising edge
RX_Data_out  output  8  last accepted byte; stable while RX_Valid is high
RX_Valid  output  1  held byte available; level signal, not a pulse
RX_Frame_Error  output  1  one-cycle pulse when the stop bit is sampled low
RX_Overrun  output  1  sticky flag: a good frame was dropped because the holding register was full
RX_Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous and active-high:
  - State goes to IDLE.
  - RX_Data_out=0x00; RX_Valid, RX_Frame_Error, RX_Overrun and RX_Busy=0.
  - Both synchronizer flops are preset to 1.
  - Reset mid-frame discards the partial byte.
- Input path: RX_Data_in passes through a 2-FF synchronizer (ASYNC_REG) to give rx_s. All decisions use rx_s.
- Counter: bit_cnt, width $clog2(CLKS_PER_BIT). It is cleared on every state entry.
- Bit index: bit_idx, 3 bits.
- States:
  - IDLE: when rx_s==0, go to START.
  - START: when bit_cnt==CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA with bit_idx=0. If 1, treat it as a glitch and return to IDLE with no flags.
  - DATA: when bit_cnt==CLKS_PER_BIT-1, shift rx_s into the shift register, LSB first. After bit_idx==7 is sampled, go to STOP; otherwise increment bit_idx.
  - STOP: when bit_cnt==CLKS_PER_BIT-1, sample rx_s. If 1, the frame is good: do a completion and go to IDLE. If 0, pulse RX_Frame_Error for one cycle, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: when rx_s==1, go to IDLE. This prevents a break condition from retriggering the receiver.
- Completion: RX_Valid rises one cycle after the stop-bit sample edge.
- Latency: from the first clk edge at which RX_Data_in is low to RX_Valid high = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 for synchronizer phase).
- Holding register rules, evaluated per cycle (comp = good completion this cycle):
  - comp and RX_Valid==0: load the byte, set RX_Valid.
  - comp, RX_Valid==1 and RX_Ack==1: load the new byte, keep RX_Valid=1, clear RX_Overrun.
  - comp, RX_Valid==1 and RX_Ack==0: keep the old byte, drop the new one, set RX_Overrun.
  - no comp and RX_Ack==1: clear RX_Valid and RX_Overrun.
  - RX_Ack while RX_Valid==0 has no effect on RX_Valid; it still clears RX_Overrun.
- Frame errors never touch RX_Data_out, RX_Valid or RX_Overrun.
- Sampling point is mid-bit. Tolerated baud mismatch is the usual ±~4% for 8N1.

Decomposition:
- Package uart_pkg:
  - rx state encoding: IDLE, START, DATA, STOP, WAIT_IDLE.
  - DATA_BITS=8.
  - Default CLKS_PER_BIT constant, shared with the transmitter.
- One sub-module: uart_sync_2ff, a generic 2-flop synchronizer with a reset value parameter. Instantiate it with reset value 1. The TX path can reuse it.
- The state machine, counter, shift register and holding register stay in uart_rx.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Nominal byte: drive frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> RX_Data_out=0xA5, RX_Valid high 155±1 cycles after the start edge, RX_Busy low thereafter. RX_Ack -> RX_Valid=0 next cycle.
- Start glitch: RX_Data_in low for 4 cycles, then high -> returns to IDLE with no RX_Valid and no RX_Frame_Error. A following 0x3C frame is received correctly.
- Framing error: frame 0x3C with stop bit 0, line held low for 40 more cycles -> one-cycle RX_Frame_Error pulse, RX_Valid stays 0, RX_Busy high until the line returns high. A subsequent 0x7E is received correctly.
- Overrun: send 0x11 then 0x22 with no RX_Ack -> RX_Data_out=0x11, RX_Overrun=1. RX_Ack -> RX_Valid=0 and RX_Overrun=0.
- Ack coincident with completion: 0x11 is held, and RX_Ack is asserted on the completion cycle of 0x22 -> RX_Data_out=0x22, RX_Valid stays 1, RX_Overrun=0.
- Reset mid-frame: assert reset during data bit 3 of 0xFF -> all outputs 0 immediately. After release, frame 0x5A yields RX_Data_out=0x5A, RX_Valid=1, and no error flags.
